// File: rtl/mips_run_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_run_pkg
// Description : Shared types and mode codes for the MIPS run controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_run_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_IDLE     = 3'd1,
        ST_RUN      = 3'd2,
        ST_STEP     = 3'd3,
        ST_RUN_N    = 3'd4,
        ST_BREAK    = 3'd5
    } run_state_t;

    // Run-mode encodings on the mode input
    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_RUNN = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mips_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : mips_down_counter
// Description : Loadable down counter with zero flag; saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load wins over decrement; decrement stops at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Count register, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/mips_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_run_ctrl
// Description : CPU run controller: reset hold, run / step / run-N,
//               breakpoint stop and executed-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_run_ctrl
    import mips_run_pkg::*;
#(
    parameter int RST_CYCLES = 8,
    parameter int CNT_W      = 32,
    parameter int PC_W       = 32,
    parameter int STEP_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              go,
    input  logic [STEP_W-1:0] n_cycles,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]   pc,
    output logic              cpu_rst_n,
    output logic              cpu_ce,
    output logic              busy,
    output logic              bp_hit,
    output logic [CNT_W-1:0]  cycle_cnt
);

    // The hold counter is loaded on the first hold cycle, so it needs two
    // fewer counts than the hold length to exit after exactly RST_CYCLES.
    localparam int HOLD_W     = $clog2(RST_CYCLES + 1);
    localparam int HOLD_LOAD  = (RST_CYCLES >= 2) ? (RST_CYCLES - 2) : 0;
    localparam bit HOLD_SHORT = (RST_CYCLES <= 1);

    run_state_t       state_q, state_d;
    logic             skip_bp_q, skip_bp_d;
    logic             hold_loaded_q, hold_loaded_d;
    logic             cpu_rst_n_q, busy_q, bp_hit_q;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    logic w_active, w_halt, w_bp_match, w_ce, w_start_ok, w_go_accept;
    logic w_hold_load, w_hold_dec, w_hold_zero, w_hold_done;
    logic w_runn_load, w_runn_dec, w_runn_zero;

    // Enable/breakpoint decode; a breakpoint is skipped once after resume
    always_comb begin
        w_active    = (state_q == ST_RUN) || (state_q == ST_STEP) ||
                      (state_q == ST_RUN_N);
        w_halt      = (mode == MODE_HALT);
        w_bp_match  = bp_en && (pc == bp_addr) && !skip_bp_q;
        w_ce        = w_active && !w_halt && !w_bp_match;
        w_start_ok  = (mode == MODE_RUN) || (mode == MODE_STEP) ||
                      ((mode == MODE_RUNN) && (n_cycles != '0));
        w_go_accept = go && w_start_ok &&
                      ((state_q == ST_IDLE) || (state_q == ST_BREAK));
        w_hold_load = (state_q == ST_RST_HOLD) && !hold_loaded_q;
        w_hold_dec  = (state_q == ST_RST_HOLD) && hold_loaded_q;
        w_hold_done = hold_loaded_q ? w_hold_zero : HOLD_SHORT;
        w_runn_load = w_go_accept && (mode == MODE_RUNN);
        w_runn_dec  = w_ce && (state_q == ST_RUN_N);
    end

    assign cpu_ce = w_ce;

    mips_down_counter #(
        .WIDTH (HOLD_W)
    ) u_hold_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_hold_load),
        .load_val (HOLD_W'(HOLD_LOAD)),
        .dec      (w_hold_dec),
        .zero     (w_hold_zero)
    );

    // RUN_N remaining count holds n_cycles-1 so zero marks the last cycle
    mips_down_counter #(
        .WIDTH (STEP_W)
    ) u_runn_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_runn_load),
        .load_val (n_cycles - STEP_W'(1)),
        .dec      (w_runn_dec),
        .zero     (w_runn_zero)
    );

    // Next-state logic; breakpoint outranks halt and RUN_N completion
    always_comb begin
        state_d       = state_q;
        skip_bp_d     = skip_bp_q;
        hold_loaded_d = (state_q == ST_RST_HOLD);
        if (w_go_accept) begin
            skip_bp_d = 1'b1;
        end else if (w_ce) begin
            skip_bp_d = 1'b0;
        end
        case (state_q)
            ST_RST_HOLD: if (w_hold_done) state_d = ST_IDLE;
            ST_IDLE, ST_BREAK: begin
                if (w_go_accept) begin
                    case (mode)
                        MODE_RUN:  state_d = ST_RUN;
                        MODE_STEP: state_d = ST_STEP;
                        MODE_RUNN: state_d = ST_RUN_N;
                        default:   state_d = state_q;
                    endcase
                end
            end
            ST_RUN: begin
                if (w_bp_match)  state_d = ST_BREAK;
                else if (w_halt) state_d = ST_IDLE;
            end
            ST_STEP: begin
                if (w_bp_match) state_d = ST_BREAK;
                else            state_d = ST_IDLE;
            end
            ST_RUN_N: begin
                if (w_bp_match)       state_d = ST_BREAK;
                else if (w_halt)      state_d = ST_IDLE;
                else if (w_runn_zero) state_d = ST_IDLE;
            end
            default: state_d = ST_RST_HOLD;
        endcase
        cycle_cnt_d = (state_q == ST_RST_HOLD) ? '0 :
                      (cycle_cnt_q + CNT_W'(w_ce));
    end

    // FSM state plus outputs registered from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RST_HOLD;
            skip_bp_q     <= 1'b0;
            hold_loaded_q <= 1'b0;
            cpu_rst_n_q   <= 1'b0;
            busy_q        <= 1'b0;
            bp_hit_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            skip_bp_q     <= skip_bp_d;
            hold_loaded_q <= hold_loaded_d;
            cpu_rst_n_q   <= (state_d != ST_RST_HOLD);
            busy_q        <= (state_d == ST_RUN) || (state_d == ST_STEP) ||
                             (state_d == ST_RUN_N);
            bp_hit_q      <= (state_d == ST_BREAK);
        end
    end

    // Executed-cycle counter, wraps naturally at its width
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cpu_rst_n = cpu_rst_n_q;
    assign busy      = busy_q;
    assign bp_hit    = bp_hit_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule
`default_nettype wire
